// File: rtl/stdp_weight_update.sv
// STDP weight update engine.
// Turns a spike timing difference and sign into a shift-decayed weight delta,
// then read-modify-writes a small synaptic weight file with saturation.
// A separate registered read port serves the neuron datapath.
module stdp_weight_update #(
  parameter int NUM_SYN         = 16,
  parameter int WEIGHT_W        = 8,
  parameter int W_INIT          = 128,
  parameter int A_PLUS          = 32,
  parameter int A_MINUS         = 32,
  parameter int DECAY_STEP_LOG2 = 1,
  localparam int ADDR_W         = (NUM_SYN > 1) ? $clog2(NUM_SYN) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                upd_valid,
  output logic                upd_ready,
  input  logic [ADDR_W-1:0]   syn_addr,
  input  logic [3:0]          timing_diff,
  input  logic                signed_flag,
  input  logic                learn_en,
  output logic                done,
  output logic [WEIGHT_W-1:0] weight_out,
  output logic                sat_hit,
  output logic [15:0]         upd_count,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [WEIGHT_W-1:0] rd_data
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_CALC  = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  localparam logic [WEIGHT_W-1:0] INIT_W    = W_INIT[WEIGHT_W-1:0];
  localparam logic [WEIGHT_W-1:0] W_MAX     = '1;
  localparam logic [WEIGHT_W:0]   AMP_P     = A_PLUS[WEIGHT_W:0];
  localparam logic [WEIGHT_W:0]   AMP_M     = A_MINUS[WEIGHT_W:0];
  localparam logic [ADDR_W:0]     SYN_LIMIT = NUM_SYN[ADDR_W:0];

  logic [1:0]          r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [3:0]          r_dt;
  logic                r_sign;
  logic                r_learn;
  logic [WEIGHT_W-1:0] r_cur;
  logic [WEIGHT_W-1:0] r_result;
  logic                r_clamp;
  logic                r_done;
  logic [WEIGHT_W-1:0] r_weightOut;
  logic                r_satHit;
  logic [15:0]         r_updCount;
  logic [WEIGHT_W-1:0] r_rdData;
  logic [WEIGHT_W-1:0] r_mem [NUM_SYN];

  logic                w_inRange;
  logic                w_rdInRange;
  logic [3:0]          w_shift;
  logic [WEIGHT_W:0]   w_amp;
  logic [WEIGHT_W:0]   w_mag;
  logic [WEIGHT_W+1:0] w_sum;
  logic [WEIGHT_W-1:0] w_diff;
  logic [WEIGHT_W-1:0] w_next;
  logic                w_clamp;
  logic                w_wrEn;

  assign w_inRange   = ({1'b0, r_addr} < SYN_LIMIT);
  assign w_rdInRange = ({1'b0, rd_addr} < SYN_LIMIT);
  assign w_wrEn      = (r_state == S_WRITE) && w_inRange;

  // Exponential decay approximated by halving the amplitude every 2^DECAY_STEP_LOG2 steps
  always_comb begin
    w_shift = r_dt >> DECAY_STEP_LOG2;
    w_amp   = r_sign ? AMP_M : AMP_P;
    w_mag   = r_learn ? (w_amp >> w_shift) : '0;
    w_sum   = {2'b00, r_cur} + {1'b0, w_mag};
    w_diff  = r_cur - w_mag[WEIGHT_W-1:0];
  end

  // Saturating add for potentiation, floor at zero for depression
  always_comb begin
    w_next  = r_cur;
    w_clamp = 1'b0;
    if (!w_inRange) begin
      w_next  = '0;
      w_clamp = 1'b0;
    end else if (!r_sign) begin
      if (w_sum > {2'b00, W_MAX}) begin
        w_next  = W_MAX;
        w_clamp = 1'b1;
      end else begin
        w_next = w_sum[WEIGHT_W-1:0];
      end
    end else begin
      if (w_mag > {1'b0, r_cur}) begin
        w_next  = '0;
        w_clamp = 1'b1;
      end else begin
        w_next = w_diff;
      end
    end
  end

  // Request capture and the IDLE/READ/CALC/WRITE sequence
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_dt     <= '0;
      r_sign   <= 1'b0;
      r_learn  <= 1'b0;
      r_cur    <= '0;
      r_result <= '0;
      r_clamp  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (upd_valid) begin
            r_addr  <= syn_addr;
            r_dt    <= timing_diff;
            r_sign  <= signed_flag;
            r_learn <= learn_en;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          r_cur   <= w_inRange ? r_mem[r_addr] : '0;
          r_state <= S_CALC;
        end
        S_CALC: begin
          r_result <= w_next;
          r_clamp  <= w_clamp;
          r_state  <= S_WRITE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Weight file: every entry back to the initial weight on reset, written only in WRITE
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SYN; i++) begin
        r_mem[i] <= INIT_W;
      end
    end else if (w_wrEn) begin
      r_mem[r_addr] <= r_result;
    end
  end

  // Completion pulse, reported weight, clamp flag and saturating update counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done      <= 1'b0;
      r_weightOut <= '0;
      r_satHit    <= 1'b0;
      r_updCount  <= '0;
    end else begin
      r_done   <= (r_state == S_WRITE);
      r_satHit <= (r_state == S_WRITE) && r_clamp;
      if (r_state == S_WRITE) begin
        r_weightOut <= r_result;
        if (r_updCount != 16'hFFFF) begin
          r_updCount <= r_updCount + 16'd1;
        end
      end
    end
  end

  // Registered read port; a same-cycle write to the same entry is forwarded
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdData <= INIT_W;
    end else if (w_wrEn && (rd_addr == r_addr)) begin
      r_rdData <= r_result;
    end else if (w_rdInRange) begin
      r_rdData <= r_mem[rd_addr];
    end else begin
      r_rdData <= '0;
    end
  end

  assign upd_ready  = (r_state == S_IDLE);
  assign done       = r_done;
  assign weight_out = r_weightOut;
  assign sat_hit    = r_satHit;
  assign upd_count  = r_updCount;
  assign rd_data    = r_rdData;

endmodule

// File: tb/tb_stdp_weight_update.sv
// Self-checking bench for stdp_weight_update.
// Directed scenarios plus randomized updates, each checked against a
// behavioural model of the weight file written as plain arithmetic.
module tb_stdp_weight_update;

  localparam int NUM_SYN = 16;
  localparam int W_INIT  = 128;
  localparam int A_PLUS  = 32;
  localparam int A_MINUS = 32;
  localparam int W_MAX   = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        upd_valid;
  logic        upd_ready;
  logic [3:0]  syn_addr;
  logic [3:0]  timing_diff;
  logic        signed_flag;
  logic        learn_en;
  logic        done;
  logic [7:0]  weight_out;
  logic        sat_hit;
  logic [15:0] upd_count;
  logic [3:0]  rd_addr;
  logic [7:0]  rd_data;

  int compareCount = 0;
  int failCount    = 0;
  int modelMem [NUM_SYN];
  int modelCount;

  stdp_weight_update dut (
    .clk         (clk),
    .rst         (rst),
    .upd_valid   (upd_valid),
    .upd_ready   (upd_ready),
    .syn_addr    (syn_addr),
    .timing_diff (timing_diff),
    .signed_flag (signed_flag),
    .learn_en    (learn_en),
    .done        (done),
    .weight_out  (weight_out),
    .sat_hit     (sat_hit),
    .upd_count   (upd_count),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Hard stop in case the design never responds
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic void modelReset();
    for (int i = 0; i < NUM_SYN; i++) modelMem[i] = W_INIT;
    modelCount = 0;
  endfunction

  // Amplitude halves every two dt steps; learning disabled means no change
  function automatic void modelUpdate(input int addr, input int dt, input int sign, input int learn,
                                      output int newW, output bit sat);
    int amp;
    int mag;
    int w;
    amp = (sign != 0) ? A_MINUS : A_PLUS;
    mag = (learn != 0) ? amp / (1 << (dt / 2)) : 0;
    w   = modelMem[addr];
    sat = 1'b0;
    if (sign == 0) begin
      if (w + mag > W_MAX) begin
        newW = W_MAX;
        sat  = 1'b1;
      end else begin
        newW = w + mag;
      end
    end else begin
      if (mag > w) begin
        newW = 0;
        sat  = 1'b1;
      end else begin
        newW = w - mag;
      end
    end
    modelMem[addr] = newW;
    if (modelCount < 65535) modelCount++;
  endfunction

  // One complete update: wait for ready, present the request, check the result pulse
  task automatic applyStimulus(input int addr, input int dt, input int sign, input int learn, input string tag);
    int waitCycles;
    int lat;
    int newW;
    bit sat;
    @(negedge clk);
    waitCycles = 0;
    while (upd_ready !== 1'b1 && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput({tag, "_ready"}, 32'(upd_ready), 32'd1);
    syn_addr    = 4'(addr);
    timing_diff = 4'(dt);
    signed_flag = 1'(sign);
    learn_en    = 1'(learn);
    rd_addr     = 4'(addr);
    upd_valid   = 1'b1;
    @(posedge clk);
    #1;
    upd_valid   = 1'b0;
    syn_addr    = 4'($urandom);
    timing_diff = 4'($urandom);
    signed_flag = 1'($urandom);
    learn_en    = 1'($urandom);
    modelUpdate(addr, dt, sign, learn, newW, sat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (done !== 1'b1 && lat < 10);
    checkOutput({tag, "_latency"}, 32'(lat), 32'd3);
    checkOutput({tag, "_weight"}, 32'(weight_out), 32'(newW));
    checkOutput({tag, "_sat"}, 32'(sat_hit), 32'(sat));
    checkOutput({tag, "_bypass"}, 32'(rd_data), 32'(newW));
    checkOutput({tag, "_count"}, 32'(upd_count), 32'(modelCount));
    @(posedge clk);
    #1;
    checkOutput({tag, "_pulse"}, 32'(done), 32'd0);
  endtask

  task automatic readCheck(input int addr, input string tag);
    @(negedge clk);
    rd_addr = 4'(addr);
    @(posedge clk);
    #1;
    checkOutput(tag, 32'(rd_data), 32'(modelMem[addr]));
  endtask

  initial begin
    int expA;
    int expB;
    bit satA;
    bit satB;
    int firstDone;
    int secondDone;
    int doneSeen;

    rst         = 1'b1;
    upd_valid   = 1'b0;
    syn_addr    = '0;
    timing_diff = '0;
    signed_flag = 1'b0;
    learn_en    = 1'b1;
    rd_addr     = '0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_rddata", 32'(rd_data), 32'd128);
    rst = 1'b0;
    checkOutput("rst_ready", 32'(upd_ready), 32'd1);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_sat", 32'(sat_hit), 32'd0);
    checkOutput("rst_wout", 32'(weight_out), 32'd0);
    checkOutput("rst_count", 32'(upd_count), 32'd0);
    for (int a = 0; a < NUM_SYN; a++) readCheck(a, $sformatf("init_rd%0d", a));

    // Basic potentiation and decayed depression on the same entry
    applyStimulus(3, 0, 0, 1, "pot_a3");
    checkOutput("pot_a3_value", 32'(modelMem[3]), 32'd160);
    readCheck(3, "rd_a3_after_pot");
    applyStimulus(3, 5, 1, 1, "dep_a3");
    checkOutput("dep_a3_value", 32'(modelMem[3]), 32'd152);

    // Climb to the ceiling; the last step clamps
    for (int k = 0; k < 4; k++) applyStimulus(7, 0, 0, 1, $sformatf("sat_hi%0d", k));
    readCheck(7, "rd_a7_max");

    // Walk down to 4, then a full-amplitude depression floors at zero
    applyStimulus(9, 0, 1, 1, "dn32a");
    applyStimulus(9, 0, 1, 1, "dn32b");
    applyStimulus(9, 0, 1, 1, "dn32c");
    applyStimulus(9, 2, 1, 1, "dn16");
    applyStimulus(9, 4, 1, 1, "dn8");
    applyStimulus(9, 6, 1, 1, "dn4");
    applyStimulus(9, 0, 1, 1, "sat_lo");
    readCheck(9, "rd_a9_zero");

    // Zero-delta updates still complete and count
    applyStimulus(5, 15, 0, 1, "dt15");
    applyStimulus(6, 0, 0, 0, "nolearn");
    readCheck(6, "rd_a6_frozen");

    // Back-to-back requests held on the bus: the second waits for ready
    @(negedge clk);
    while (upd_ready !== 1'b1) @(negedge clk);
    syn_addr    = 4'd10;
    timing_diff = 4'd0;
    signed_flag = 1'b0;
    learn_en    = 1'b1;
    rd_addr     = 4'd10;
    upd_valid   = 1'b1;
    @(posedge clk);
    #1;
    syn_addr    = 4'd11;
    timing_diff = 4'd2;
    signed_flag = 1'b1;
    learn_en    = 1'b1;
    modelUpdate(10, 0, 0, 1, expA, satA);
    modelUpdate(11, 2, 1, 1, expB, satB);
    firstDone  = 0;
    secondDone = 0;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        if (firstDone == 0) begin
          firstDone = e;
          checkOutput("hs_first_weight", 32'(weight_out), 32'(expA));
        end else if (secondDone == 0) begin
          secondDone = e;
          checkOutput("hs_second_weight", 32'(weight_out), 32'(expB));
        end
      end
      if (e == 4) upd_valid = 1'b0;
    end
    checkOutput("hs_first_at", 32'(firstDone), 32'd3);
    checkOutput("hs_second_at", 32'(secondDone), 32'd7);
    checkOutput("hs_count", 32'(upd_count), 32'(modelCount));
    readCheck(11, "rd_a11_hs");

    // Randomized updates against the model
    for (int n = 0; n < 30; n++) begin
      applyStimulus(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 1)), int'($urandom_range(0, 3) != 0),
                    $sformatf("rnd%0d", n));
    end
    for (int a = 0; a < NUM_SYN; a++) readCheck(a, $sformatf("rnd_rd%0d", a));

    // Reset while the update sits in CALC: nothing is written and no pulse appears
    @(negedge clk);
    while (upd_ready !== 1'b1) @(negedge clk);
    syn_addr    = 4'd12;
    timing_diff = 4'd0;
    signed_flag = 1'b0;
    learn_en    = 1'b1;
    rd_addr     = 4'd12;
    upd_valid   = 1'b1;
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
    doneSeen = 0;
    for (int e = 0; e < 5; e++) begin
      if (done === 1'b1) doneSeen++;
      @(posedge clk);
      #1;
    end
    checkOutput("abort_no_done", 32'(doneSeen), 32'd0);
    checkOutput("abort_count", 32'(upd_count), 32'd0);
    checkOutput("abort_ready", 32'(upd_ready), 32'd1);
    readCheck(12, "abort_rd_a12");
    readCheck(3, "abort_rd_a3");
    readCheck(7, "abort_rd_a7");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule

// File: doc/stdp_weight_update.md
Name: stdp_weight_update

Overview:
- Downstream consumer of the timing-difference priority encoder in the STDP learning engine.
- Takes a 4-bit spike timing difference and a sign flag per pre/post pair. Converts them to a decayed weight delta with a shift-based exponential approximation.
- Read-modify-writes an on-block synaptic weight register file with saturation. Exposes an independent weight read port for the neuron datapath.

Parameters:
- NUM_SYN, 16, number of synapse weights stored; ADDR_W = clog2(NUM_SYN).
- WEIGHT_W, 8, unsigned weight width.
- W_INIT, 128, weight value loaded into every entry on reset.
- A_PLUS, 32, potentiation amplitude at dt=0.
- A_MINUS, 32, depression amplitude at dt=0.
- DECAY_STEP_LOG2, 1, amplitude halves every 2^DECAY_STEP_LOG2 dt steps.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- upd_valid  in  1  update request (timing_diff/signed_flag/syn_addr valid).
- upd_ready  out  1  block can accept a request this cycle.
- syn_addr  in  ADDR_W  synapse to update.
- timing_diff  in  4  spike timing difference 0..15 from encoder.
- signed_flag  in  1  0 = potentiation (pre before post), 1 = depression.
- learn_en  in  1  0 forces delta to 0 (weights frozen, handshake still completes).
- done  out  1  one-cycle pulse when write-back occurs.
- weight_out  out  WEIGHT_W  new weight written, valid while done=1.
- sat_hit  out  1  one-cycle pulse with done when result was clamped.
- upd_count  out  16  saturating count of completed updates.
- rd_addr  in  ADDR_W  read port address.
- rd_data  out  WEIGHT_W  registered weight at rd_addr.

Behaviour:
- Reset: all NUM_SYN entries = W_INIT; FSM=IDLE; upd_ready=1; done=0; sat_hit=0; weight_out=0; upd_count=0; rd_data=W_INIT.
- FSM states: IDLE -> READ -> CALC -> WRITE -> IDLE.
  - IDLE: upd_ready=1. On upd_valid&&upd_ready, latch syn_addr, timing_diff, signed_flag and learn_en, then go to READ.
  - READ: upd_ready=0; register mem[addr] into w_cur.
  - CALC: shift = timing_diff >> DECAY_STEP_LOG2; mag = (signed_flag ? A_MINUS : A_PLUS) >> shift; mag=0 if latched learn_en=0.
    - Potentiation: sum = w_cur + mag in WEIGHT_W+1 bits, clamp to 2^WEIGHT_W-1.
    - Depression: clamp at 0 when mag > w_cur.
    - Register the result and the clamp flag.
  - WRITE: mem[addr] <= result; done=1; weight_out=result; sat_hit=clamp; upd_count increments unless already 16'hFFFF. Return to IDLE.
- Latency: request accepted at edge T -> done high in cycle T+3. Throughput is one update per 4 cycles; upd_ready rises the cycle after WRITE.
- upd_valid while upd_ready=0 is ignored, not queued. The requester must hold the request until it is accepted.
- Inputs are sampled only at acceptance. Changes to the request or learn_en during READ/CALC/WRITE have no effect.
- Read port: rd_data <= mem[rd_addr] every edge (1-cycle latency). If WRITE targets rd_addr in the same cycle, rd_data returns the newly written value (write-first bypass).
- Reset mid-operation (any non-IDLE state): abort with no write-back and no done pulse. All entries and upd_count return to reset values.
- timing_diff range 0..15 is fully legal. Large shifts produce mag=0, so the weight is unchanged but done still pulses and the update is counted.
- Out-of-range syn_addr (>= NUM_SYN when NUM_SYN is not a power of 2): accepted, no write, done pulses with weight_out=0.

Test Plan:
- Reset then read all 16 addresses -> rd_data=128 each; upd_ready=1, done=0, upd_count=0.
- Request addr=3, dt=0, sign=0 (defaults) -> done exactly 3 cycles after acceptance, weight_out=160, sat_hit=0; rd_addr=3 then gives 160; upd_count=1.
- Request addr=3, dt=5, sign=1 -> shift=2, mag=8, weight_out=152.
- Saturation:
  - Drive addr=7 up to 255 via repeated dt=0 potentiations -> final weight_out=255, with sat_hit=1 on the clamping update.
  - Addr=9 at 4, dt=0, sign=1 -> weight_out=0, sat_hit=1.
- Zero-delta cases:
  - dt=15 sign=0 -> mag=0, weight unchanged, done pulses, upd_count increments.
  - learn_en=0 at acceptance, dt=0 -> weight unchanged.
- Handshake and reset:
  - Hold upd_valid with a second request during busy -> second request accepted only when upd_ready returns, done pulses 4 cycles apart.
  - Assert rst in CALC -> no done pulse; entry reads back 128.
